// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU-side memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE / BUS / RESP)
//   master_e    : requesting master identity (INSTR / DATA)
//   *_DEF       : default widths and timeout used by wb_mem_arbiter
package cpu_bus_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } master_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker (purely combinational).
//   req_i[0]     : instruction port requesting
//   req_i[1]     : data port requesting
//   last_grant_i : master granted most recently
//   grant_o      : winner; only meaningful when |req_i
// A lone requester always wins; on a tie the master not granted last wins.
module arb_rr2
  import cpu_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_e    last_grant_i,
  output master_e    grant_o
);

  always_comb begin
    grant_o = INSTR;
    if (req_i == 2'b11) begin
      grant_o = (last_grant_i == INSTR) ? DATA : INSTR;
    end else if (req_i[1]) begin
      grant_o = DATA;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Arbitrates a CPU instruction-fetch port and a load/store port onto one
// shared memory bus. One transaction in flight at a time:
// IDLE (pick + latch) -> BUS (strobe until ack/timeout) -> RESP (one-cycle ack).
//   sys_clk, sys_rst        : clock, async active-high reset
//   instr_addr_i/stb_i      : fetch request; instr_data_o/ack_o response
//   data_addr_i/data_i/we_i/stb_i : load/store request; data_data_o/ack_o response
//   mem_addr_o/data_o/we_o/stb_o  : shared memory request
//   mem_data_i/ack_i        : memory response
//   timeout_o               : pulse in RESP of an aborted transaction
//   busy_o                  : FSM not in IDLE
module wb_mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [ADDR_W-1:0] instr_addr_i,
  input  logic              instr_stb_i,
  output logic [DATA_W-1:0] instr_data_o,
  output logic              instr_ack_o,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_data_i,
  input  logic              data_we_i,
  input  logic              data_stb_i,
  output logic [DATA_W-1:0] data_data_o,
  output logic              data_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_we_o,
  output logic              mem_stb_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              timeout_o,
  output logic              busy_o
);

  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  arb_state_e        state_q, state_d;
  // last_grant_q is only rewritten on IDLE->BUS, so during BUS/RESP it
  // also names the owner of the current transaction.
  master_e           last_grant_q, last_grant_d;
  master_e           pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] idata_q, idata_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic              to_q, to_d;

  arb_rr2 u_rr (
    .req_i        ({data_stb_i, instr_stb_i}),
    .last_grant_i (last_grant_q),
    .grant_o      (pick)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    idata_d      = idata_q;
    ddata_d      = ddata_q;
    to_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (instr_stb_i || data_stb_i) begin
          state_d      = BUS;
          last_grant_d = pick;
          cnt_d        = '0;
          if (pick == DATA) begin
            addr_d  = data_addr_i;
            wdata_d = data_data_i;
            we_d    = data_we_i;
          end else begin
            addr_d  = instr_addr_i;
            wdata_d = '0;
            we_d    = 1'b0;
          end
        end
      end
      BUS: begin
        // An ack on the final allowed cycle wins over the abort.
        if (mem_ack_i) begin
          state_d = RESP;
          if (last_grant_q == DATA) ddata_d = mem_data_i;
          else                      idata_d = mem_data_i;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          state_d = RESP;
          to_d    = 1'b1;
          if (last_grant_q == DATA) ddata_d = '0;
          else                      idata_d = '0;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      last_grant_q <= INSTR;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      idata_q      <= '0;
      ddata_q      <= '0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      idata_q      <= idata_d;
      ddata_q      <= ddata_d;
      to_q         <= to_d;
    end
  end

  // All outputs come straight from registers so reset clears them at once.
  assign mem_stb_o    = (state_q == BUS);
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = wdata_q;
  assign mem_we_o     = we_q;
  assign instr_ack_o  = (state_q == RESP) && (last_grant_q == INSTR);
  assign data_ack_o   = (state_q == RESP) && (last_grant_q == DATA);
  assign instr_data_o = idata_q;
  assign data_data_o  = ddata_q;
  assign timeout_o    = to_q;
  assign busy_o       = (state_q != IDLE);

endmodule
